// File: rtl/path_probe_ctrl.sv
// Launches edges into an external delay chain and checks the synchronized result a
// programmable number of cycles later. Define PROBE_FIRST_FAIL_EN to capture the first failing trial index.
module path_probe_ctrl #(
    parameter int INVERTING = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       sampleDelay,
    input  logic [CNT_W-1:0] numTrials,
    output logic             pathInput,
    input  logic             pathResult,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] passCount,
    output logic [CNT_W-1:0] failCount,
    output logic [CNT_W-1:0] firstFailIdx
);

    localparam logic INV_BIT = (INVERTING != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        SETTLE = 3'd4,
        DONE   = 3'd5
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state;
    state_t           state_nxt;

    logic             sync_p0;
    logic             syncResult;

    logic [7:0]       delayLat;
    logic [7:0]       delayLat_nxt;
    logic [CNT_W-1:0] trialsLat;
    logic [CNT_W-1:0] trialsLat_nxt;
    logic [7:0]       delayCnt;
    logic [7:0]       delayCnt_nxt;
    logic [CNT_W-1:0] trialIdx;
    logic [CNT_W-1:0] trialIdx_nxt;
    logic [CNT_W-1:0] passCount_nxt;
    logic [CNT_W-1:0] failCount_nxt;
    logic             pathInput_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             match;
    logic [CNT_W-1:0] trialIdx_inc;

    // pathResult is asynchronous to clk; only syncResult is ever looked at
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0    <= 1'b0;
            syncResult <= 1'b0;
        end else begin
            sync_p0    <= pathResult;
            syncResult <= sync_p0;
        end
    end

    assign match        = (syncResult == (pathInput ^ INV_BIT));
    assign trialIdx_inc = trialIdx + CNT_W'(1);

`ifdef PROBE_FIRST_FAIL_EN
    logic [CNT_W-1:0] firstFailIdx_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        delayLat_nxt  = delayLat;
        trialsLat_nxt = trialsLat;
        delayCnt_nxt  = delayCnt;
        trialIdx_nxt  = trialIdx;
        passCount_nxt = passCount;
        failCount_nxt = failCount;
        pathInput_nxt = pathInput;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
`ifdef PROBE_FIRST_FAIL_EN
        firstFailIdx_nxt = firstFailIdx;
`endif

        // abort overrides everything and leaves counts and pathInput untouched
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        delayLat_nxt  = sampleDelay;
                        trialsLat_nxt = numTrials;
                        trialIdx_nxt  = '0;
                        passCount_nxt = '0;
                        failCount_nxt = '0;
`ifdef PROBE_FIRST_FAIL_EN
                        firstFailIdx_nxt = '0;
`endif
                        busy_nxt      = 1'b1;
                        state_nxt     = (numTrials == '0) ? DONE : LAUNCH;
                    end
                end
                LAUNCH: begin
                    pathInput_nxt = ~pathInput;
                    delayCnt_nxt  = delayLat;
                    state_nxt     = WAIT;
                end
                WAIT: begin
                    if (delayCnt == 8'd0) begin
                        state_nxt = SAMPLE;
                    end else begin
                        delayCnt_nxt = delayCnt - 8'd1;
                    end
                end
                SAMPLE: begin
                    if (match) begin
                        passCount_nxt = sat_inc(passCount);
                    end else begin
                        failCount_nxt = sat_inc(failCount);
`ifdef PROBE_FIRST_FAIL_EN
                        // failCount never returns to zero within a run, so zero marks the first failure
                        if (failCount == '0) begin
                            firstFailIdx_nxt = trialIdx;
                        end
`endif
                    end
                    delayCnt_nxt = delayLat;
                    state_nxt    = SETTLE;
                end
                SETTLE: begin
                    if (delayCnt == 8'd0) begin
                        trialIdx_nxt = trialIdx_inc;
                        state_nxt    = (trialIdx_inc == trialsLat) ? DONE : LAUNCH;
                    end else begin
                        delayCnt_nxt = delayCnt - 8'd1;
                    end
                end
                DONE: begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delayLat  <= '0;
            trialsLat <= '0;
            delayCnt  <= '0;
            trialIdx  <= '0;
            passCount <= '0;
            failCount <= '0;
            pathInput <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            delayLat  <= delayLat_nxt;
            trialsLat <= trialsLat_nxt;
            delayCnt  <= delayCnt_nxt;
            trialIdx  <= trialIdx_nxt;
            passCount <= passCount_nxt;
            failCount <= failCount_nxt;
            pathInput <= pathInput_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

`ifdef PROBE_FIRST_FAIL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            firstFailIdx <= '0;
        end else begin
            firstFailIdx <= firstFailIdx_nxt;
        end
    end
`else
    assign firstFailIdx = '0;
`endif

endmodule

// File: tb/tb_path_probe_ctrl.sv
// Directed bench for path_probe_ctrl: table of loopback runs plus abort, reset,
// zero-trial and start-while-busy sequences against a 3-cycle chain model.
module tb_path_probe_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [7:0]       sampleDelay;
    logic [CNT_W-1:0] numTrials;
    logic             pathInput;
    logic             pathResult;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] passCount;
    logic [CNT_W-1:0] failCount;
    logic [CNT_W-1:0] firstFailIdx;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    path_probe_ctrl #(.INVERTING(0), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .sampleDelay (sampleDelay),
        .numTrials   (numTrials),
        .pathInput   (pathInput),
        .pathResult  (pathResult),
        .busy        (busy),
        .done        (done),
        .passCount   (passCount),
        .failCount   (failCount),
        .firstFailIdx(firstFailIdx)
    );

    // Chain model: pathInput delayed 3 cycles, optional inversion or single-trial corruption
    logic d1, d2, d3, pi_prev;
    int   launches;
    logic invert_all, corrupt_en;
    int   corrupt_base;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d1 <= 1'b0; d2 <= 1'b0; d3 <= 1'b0; pi_prev <= 1'b0; launches <= 0;
        end else begin
            d1 <= pathInput; d2 <= d1; d3 <= d2; pi_prev <= pathInput;
            if (pathInput != pi_prev) launches <= launches + 1;
        end
    end

    assign pathResult = d3 ^ invert_all ^ (corrupt_en && ((launches - corrupt_base) == 3));

    typedef struct {
        logic        inv;
        logic        corrupt;
        logic        poke;
        logic [7:0]  sd;
        logic [15:0] nt;
        int          exp_pass;
        int          exp_fail;
        int          exp_ffi;
        int          exp_tog;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_case(input int id, input vec_t v);
        int   tog = 0;
        int   dpulse = 0;
        int   budget;
        int   ffi_exp;
        logic prev;
        budget = (2 * int'(v.sd) + 8) * int'(v.nt) + 20;
`ifdef PROBE_FIRST_FAIL_EN
        ffi_exp = v.exp_ffi;
`else
        ffi_exp = 0;
`endif
        @(negedge clk);
        invert_all   = v.inv;
        corrupt_en   = v.corrupt;
        corrupt_base = launches;
        sampleDelay  = v.sd;
        numTrials    = v.nt;
        start        = 1'b1;
        prev         = pathInput;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d_busy_start", id), busy, 1);
        for (int c = 0; c < budget; c++) begin
            if (pathInput !== prev) tog++;
            prev = pathInput;
            if (done === 1'b1) dpulse++;
            if (v.poke && c == 15) begin
                start = 1'b1; numTrials = 16'd1; sampleDelay = 8'd0;
            end else if (v.poke && c == 16) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check($sformatf("v%0d_done_pulses", id), dpulse, 1);
        check($sformatf("v%0d_toggles", id), tog, v.exp_tog);
        check($sformatf("v%0d_pass", id), passCount, v.exp_pass);
        check($sformatf("v%0d_fail", id), failCount, v.exp_fail);
        check($sformatf("v%0d_first_fail", id), firstFailIdx, ffi_exp);
        check($sformatf("v%0d_busy_end", id), busy, 0);
    endtask

    initial begin
        int   base;
        int   w;
        int   cnt;
        logic pi_hold;

        rst = 1'b0; start = 1'b0; abort = 1'b0; sampleDelay = '0; numTrials = '0;
        invert_all = 1'b0; corrupt_en = 1'b0; corrupt_base = 0;

        //          inv   cor   poke  sd     nt     pass fail ffi tog
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'd8, 16'd4, 4, 0, 0, 4};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'd0, 16'd4, 0, 4, 0, 4};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 8'd8, 16'd5, 0, 5, 0, 5};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'd8, 16'd5, 4, 1, 2, 5};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'd3, 16'd3, 0, 3, 0, 3};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 8'd4, 16'd3, 3, 0, 0, 3};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'd4, 16'd1, 1, 0, 0, 1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 8'd8, 16'd4, 4, 0, 0, 4};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 8'd4, 16'd4, 3, 1, 2, 4};

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pathInput", pathInput, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", passCount, 0);
        check("rst_fail", failCount, 0);
        check("rst_ffi", firstFailIdx, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_case(i, vecs[i]);

        // zero trials: busy for one cycle, done one cycle later
        invert_all = 1'b0; corrupt_en = 1'b0;
        @(negedge clk);
        pi_hold = pathInput;
        numTrials = '0; sampleDelay = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("nt0_busy_c1", busy, 1);
        check("nt0_done_c1", done, 0);
        check("nt0_pass", passCount, 0);
        check("nt0_fail", failCount, 0);
        @(negedge clk);
        check("nt0_busy_c2", busy, 0);
        check("nt0_done_c2", done, 1);
        @(negedge clk);
        check("nt0_done_c3", done, 0);
        check("nt0_pathInput", pathInput, pi_hold);

        // abort during WAIT of trial 1
        base = launches;
        sampleDelay = 8'd8; numTrials = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while ((launches - base) < 2 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("abort_wait_bound", (w < 100), 1);
        abort = 1'b1;
        pi_hold = pathInput;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1 || pathInput !== pi_hold) cnt++;
            @(negedge clk);
        end
        check("abort_no_done_no_toggle", cnt, 0);
        check("abort_pass", passCount, 1);
        check("abort_fail", failCount, 0);
        check("abort_pathInput", pathInput, pi_hold);

        // abort and start together in IDLE: no run
        start = 1'b1; abort = 1'b1; numTrials = 16'd4;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("abort_start_pass_held", passCount, 1);
        check("abort_start_pathInput", pathInput, pi_hold);

        // reset in the middle of SETTLE of trial 0
        base = launches;
        sampleDelay = 8'd8; numTrials = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while ((launches - base) < 1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("rst_wait_bound", (w < 100), 1);
        repeat (12) @(negedge clk);
        check("pre_rst_pass", passCount, 1);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_pathInput", pathInput, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_pass", passCount, 0);
        check("midrst_fail", failCount, 0);
        check("midrst_ffi", firstFailIdx, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_case(9, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
